// File: rtl/phase_intensity_limiter_pkg.sv
// ---------------------------------------------------------------------------
// phase_intensity_limiter_pkg
//   Shared parameters and types for the phase/intensity slew limiter.
//   - DEPTH_DEF : default number of transducer entries per frame
//   - STAGES    : DIN_VALID -> DOUT_VALID latency in cycles
//   - ST_*      : controller states (INIT / WAIT_GAP / RUN)
//   - ctrl_t    : per-frame control (enable + step rates)
//   - ent_t     : per-entry state word kept in RAM (8.8 intensity, 8.8 phase)
// ---------------------------------------------------------------------------
package phase_intensity_limiter_pkg;

   localparam int DEPTH_DEF = 249;
   localparam int STAGES    = 2;

   typedef logic [1:0] state_t;
   localparam state_t ST_INIT     = 2'd0;
   localparam state_t ST_WAIT_GAP = 2'd1;
   localparam state_t ST_RUN      = 2'd2;

   typedef struct packed {
      logic        en;
      logic [15:0] rate_i;
      logic [15:0] rate_p;
   } ctrl_t;

   typedef struct packed {
      logic [15:0] i;
      logic [15:0] p;
   } ent_t;

endpackage

// File: rtl/phase_intensity_limiter_if.sv
// ---------------------------------------------------------------------------
// phase_intensity_limiter_if
//   Stream + control bundle for the limiter.
//   master : stream source (drives control, DIN_* ; observes DOUT_*)
//   slave  : limiter side (consumes control, DIN_* ; drives DOUT_*)
//   Signals:
//     ENABLE                 1 = limit steps, 0 = bypass
//     UPDATE_RATE_INTENSITY  max intensity step per frame (8.8)
//     UPDATE_RATE_PHASE      max phase step per frame (8.8)
//     DIN_VALID              input qualifier, DEPTH cycles per frame
//     INTENSITY_IN/PHASE_IN  target for current entry
//     INTENSITY_OUT/PHASE_OUT limited values
//     DOUT_VALID             output qualifier
// ---------------------------------------------------------------------------
interface phase_intensity_limiter_if;
   logic        ENABLE;
   logic [15:0] UPDATE_RATE_INTENSITY;
   logic [15:0] UPDATE_RATE_PHASE;
   logic        DIN_VALID;
   logic [7:0]  INTENSITY_IN;
   logic [7:0]  PHASE_IN;
   logic [7:0]  INTENSITY_OUT;
   logic [7:0]  PHASE_OUT;
   logic        DOUT_VALID;

   modport master (
      output ENABLE, UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE,
      output DIN_VALID, INTENSITY_IN, PHASE_IN,
      input  INTENSITY_OUT, PHASE_OUT, DOUT_VALID
   );

   modport slave (
      input  ENABLE, UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE,
      input  DIN_VALID, INTENSITY_IN, PHASE_IN,
      output INTENSITY_OUT, PHASE_OUT, DOUT_VALID
   );
endinterface

// File: rtl/phase_intensity_limiter_step_calc.sv
// ---------------------------------------------------------------------------
// phase_intensity_limiter_step_calc
//   Combinational one-frame step of an 8.8 value toward an 8-bit target.
//   WRAP = 0 : linear (intensity), unsigned, never overshoots.
//   WRAP = 1 : circular (phase), shortest path modulo 2^16; a half-turn
//              difference (0x8000) steps in the positive direction.
//   Ports:
//     cur  : current 8.8 state
//     tgt  : 8-bit target (integer part)
//     rate : max step per frame (8.8)
//     en   : 0 = jump straight to target
//     nxt  : next 8.8 state
// ---------------------------------------------------------------------------
module phase_intensity_limiter_step_calc #(
   parameter bit WRAP = 1'b0
) (
   input  logic [15:0] cur,
   input  logic [7:0]  tgt,
   input  logic [15:0] rate,
   input  logic        en,
   output logic [15:0] nxt
);

   logic [15:0] t;
   logic [15:0] d;
   logic [15:0] mag;
   logic        neg;

   always_comb begin
      t   = {tgt, 8'h00};
      d   = '0;
      mag = '0;
      neg = 1'b0;
      nxt = cur;
      if (WRAP) begin
         // Signed modular distance; 0x8000 is deliberately treated as
         // positive, and its unsigned magnitude (32768) is still correct.
         d   = t - cur;
         neg = d[15] && (d != 16'h8000);
         mag = neg ? (16'h0000 - d) : d;
      end else begin
         neg = (t < cur);
         mag = neg ? (cur - t) : (t - cur);
      end
      if (!en || (mag <= rate))
         nxt = t;
      else
         nxt = neg ? (cur - rate) : (cur + rate);
   end

endmodule

// File: rtl/phase_intensity_limiter.sv
// ---------------------------------------------------------------------------
// phase_intensity_limiter (top)
//   Limits the per-frame change of intensity and phase for each of DEPTH
//   transducer entries. Per-entry 8.8 state lives in a DEPTH-entry RAM that
//   is read-modify-written once per frame at the entry index.
//   After reset the RAM is cleared (INIT), then the block waits for a gap
//   in DIN_VALID (WAIT_GAP) so it only ever starts on a frame boundary.
//   Pipeline: cycle 0 = RAM read + capture, cycle 1 = step + write back,
//   outputs register at the end of cycle 1 -> DOUT_VALID is DIN_VALID
//   delayed by 2.
//   Ports:
//     CLK   : system clock
//     RST_N : asynchronous active-low reset
//     bus   : stream/control bundle (slave side)
// ---------------------------------------------------------------------------
module phase_intensity_limiter
   import phase_intensity_limiter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   phase_intensity_limiter_if.slave  bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t              state;
   logic [AW-1:0]       cnt;
   logic [AW-1:0]       init_addr;
   logic                proc;
   logic                first;
   ctrl_t               ctrl_in, ctrl_hold, ctrl_eff, ctrl_s1;
   logic [STAGES:1]     vld_pipe;
   logic [AW-1:0]       addr_s1;
   logic [7:0]          tgt_i_s1, tgt_p_s1;
   ent_t                mem [DEPTH];
   ent_t                rd_q;
   ent_t                nxt;
   logic [7:0]          int_q, ph_q;

   // Entry counter: index of the entry presented this cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         cnt <= '0;
      else if (!bus.DIN_VALID)
         cnt <= '0;
      else if (cnt != LAST)
         cnt <= cnt + AW'(1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_INIT;
         init_addr <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               init_addr <= init_addr + AW'(1);
               if (init_addr == LAST) state <= ST_WAIT_GAP;
            end
            ST_WAIT_GAP: if (!bus.DIN_VALID) state <= ST_RUN;
            ST_RUN:      state <= ST_RUN;
            default:     state <= ST_INIT;
         endcase
      end
   end

   assign proc  = (state == ST_RUN) && bus.DIN_VALID;
   assign first = proc && (cnt == '0);

   // Control is taken from the bus on the first entry and held for the rest
   // of the frame, so every entry of a frame sees the same rates.
   always_comb begin
      ctrl_in  = '{en: bus.ENABLE,
                   rate_i: bus.UPDATE_RATE_INTENSITY,
                   rate_p: bus.UPDATE_RATE_PHASE};
      ctrl_eff = first ? ctrl_in : ctrl_hold;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ctrl_hold <= '0;
         ctrl_s1   <= '0;
         addr_s1   <= '0;
         tgt_i_s1  <= '0;
         tgt_p_s1  <= '0;
         vld_pipe  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], proc};
         if (first) ctrl_hold <= ctrl_in;
         if (proc) begin
            ctrl_s1  <= ctrl_eff;
            addr_s1  <= cnt;
            tgt_i_s1 <= bus.INTENSITY_IN;
            tgt_p_s1 <= bus.PHASE_IN;
         end
      end
   end

   // State RAM. Write (stage 1, entry k-1) and read (stage 0, entry k) never
   // share an address within a frame, so no forwarding is required.
   always_ff @(posedge CLK) begin
      if (state == ST_INIT)
         mem[init_addr] <= '0;
      else if (vld_pipe[1])
         mem[addr_s1] <= nxt;
      rd_q <= mem[cnt];
   end

   phase_intensity_limiter_step_calc #(.WRAP(1'b0)) u_step_int (
      .cur  (rd_q.i),
      .tgt  (tgt_i_s1),
      .rate (ctrl_s1.rate_i),
      .en   (ctrl_s1.en),
      .nxt  (nxt.i)
   );

   phase_intensity_limiter_step_calc #(.WRAP(1'b1)) u_step_ph (
      .cur  (rd_q.p),
      .tgt  (tgt_p_s1),
      .rate (ctrl_s1.rate_p),
      .en   (ctrl_s1.en),
      .nxt  (nxt.p)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         int_q <= '0;
         ph_q  <= '0;
      end else if (vld_pipe[1]) begin
         int_q <= nxt.i[15:8];
         ph_q  <= nxt.p[15:8];
      end
   end

   assign bus.INTENSITY_OUT = int_q;
   assign bus.PHASE_OUT     = ph_q;
   assign bus.DOUT_VALID    = vld_pipe[STAGES];

endmodule

// File: doc/phase_intensity_limiter.md
PHASE_INTENSITY_LIMITER -- requirements
Module: phase_intensity_limiter

Interface
REQ-001 Parameter: DEPTH, 249, number of transducer entries per frame.
REQ-002 Port: CLK  in  1  system clock (20.48 MHz domain); one clock; reset is asynchronous and active-low.
REQ-003 Port: RST_N  in  1  asynchronous active-low reset.
REQ-004 Port: ENABLE  in  1  1 = limit steps, 0 = bypass.
REQ-005 Port: UPDATE_RATE_INTENSITY  in  16  max intensity step per frame, 8.8 fixed point.
REQ-006 Port: UPDATE_RATE_PHASE  in  16  max phase step per frame, 8.8 fixed point.
REQ-007 Port: DIN_VALID  in  1  high for DEPTH consecutive cycles per frame (stm output stream).
REQ-008 Port: INTENSITY_IN  in  8  target intensity for current entry.
REQ-009 Port: PHASE_IN  in  8  target phase for current entry.
REQ-010 Port: INTENSITY_OUT  out  8  limited intensity.
REQ-011 Port: PHASE_OUT  out  8  limited phase.
REQ-012 Port: DOUT_VALID  out  1  output qualifier, DEPTH consecutive cycles per frame.

Function
REQ-013 Per-entry state: 16-bit current intensity I and 16-bit current phase P (8.8), stored in a DEPTH-entry RAM indexed by entry counter.
REQ-014 Entry counter increments on each DIN_VALID cycle, resets to 0 on any cycle with DIN_VALID low; saturates at DEPTH-1 if DIN_VALID exceeds DEPTH cycles.
REQ-015 FSM states: INIT (clear RAM, DEPTH cycles, address 0..DEPTH-1), WAIT_GAP (wait for DIN_VALID low), RUN; INIT -> WAIT_GAP after address DEPTH-1; WAIT_GAP -> RUN on first DIN_VALID low cycle.
REQ-016 In INIT and WAIT_GAP, inputs ignored, DOUT_VALID = 0, so no partial frame is ever processed.
REQ-017 Intensity step: T = INTENSITY_IN<<8; if |T-I| <= rate then I' = T, else I' = I ± rate toward T; unsigned, no overflow.
REQ-018 Phase step: D = (PHASE_IN<<8 - P) mod 2^16 interpreted signed 16-bit; if |D| <= rate then P' = PHASE_IN<<8, else P' = P + sign(D)*rate mod 2^16 (shortest-path wrap).
REQ-019 Tie D = -32768: step in positive direction.
REQ-020 Rate 0: state holds; rate >= 0xFF00: output equals target in one frame.
REQ-021 ENABLE = 0: I' = T, P' = PHASE_IN<<8 (state tracks target, seamless re-enable).
REQ-022 Outputs: INTENSITY_OUT = I'[15:8], PHASE_OUT = P'[15:8]; I', P' written back to RAM at same index.
REQ-023 Latency: fixed 2 cycles DIN_VALID -> DOUT_VALID; DOUT_VALID is DIN_VALID delayed 2 in RUN.
REQ-024 Rates and ENABLE sampled at the first DIN_VALID cycle of a frame and held for the frame.
REQ-025 Read-modify-write of consecutive entries never collides (distinct addresses); no bypass path needed.

Reset
REQ-026 RST_N low: FSM -> INIT, counters 0, INTENSITY_OUT = 0, PHASE_OUT = 0, DOUT_VALID = 0.
REQ-027 Reset mid-frame: frame aborted, RAM re-cleared to zero by INIT, next full frame after a gap is processed.

Structure
REQ-028 State enum (INIT/WAIT_GAP/RUN) and DEPTH default belong in the shared params package.
REQ-029 One sub-module: step_calc (combinational intensity and phase step, instantiated once each mode via a WRAP parameter).

Verification
REQ-030 Reset, then 3000 idle cycles, then frame with all INTENSITY_IN=0xFF, rate 0x0100 -> first frame outputs 0x01, 255th frame 0xFF, stays 0xFF.
REQ-031 Phase from 0x00 to 0xF0, rate 0x0100 -> outputs 0xFF, 0xFE, ... reach 0xF0 after 16 frames (wrap negative path).
REQ-032 Phase target 0x80 from 0x00, rate 0x0100 -> output 0x01 first frame (tie positive).
REQ-033 ENABLE=0, random targets -> outputs equal inputs, latency 2; then ENABLE=1 with same targets -> outputs unchanged.
REQ-034 Rate 0 after converging to 0x40 -> outputs stay 0x40 while targets change.
REQ-035 Assert RST_N low at entry 100 of a frame -> DOUT_VALID 0 immediately, no output until next full frame after INIT; first outputs step from 0.
